// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline run/step/halt sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StDone = 2'd3
    } seq_state_e;

    localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use and branch-compare-in-ID hazard detection for the 5-stage pipeline.
module hazard_detect (
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic       mem_read_e_i,
    input  logic [4:0] rt_e_i,
    input  logic       reg_write_e_i,
    input  logic [4:0] write_reg_e_i,
    input  logic       mem_read_m_i,
    input  logic [4:0] write_reg_m_i,
    input  logic       branch_d_i,
    output logic       load_use_o,
    output logic       br_haz_o
);

    logic ex_dep;
    logic mem_dep;

    always_comb begin
        load_use_o = mem_read_e_i && (rt_e_i != 5'd0) &&
                     ((rt_e_i == rs_d_i) || (rt_e_i == rt_d_i));
        // Branches compare in ID, so ALU results still in EX and loads in MEM are not forwardable.
        ex_dep     = reg_write_e_i && (write_reg_e_i != 5'd0) &&
                     ((write_reg_e_i == rs_d_i) || (write_reg_e_i == rt_d_i));
        mem_dep    = mem_read_m_i && (write_reg_m_i != 5'd0) &&
                     ((write_reg_m_i == rs_d_i) || (write_reg_m_i == rt_d_i));
        br_haz_o   = branch_d_i && (ex_dep || mem_dep);
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer: stage enables, bubble insertion, HALT drain and debug counters.
module pipeline_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_halt_req,
    input  logic             i_halt_instr_D,
    input  logic [4:0]       i_instr_rs_D,
    input  logic [4:0]       i_instr_rt_D,
    input  logic             i_mem_read_E,
    input  logic [4:0]       i_instr_rt_E,
    input  logic             i_reg_write_E,
    input  logic [4:0]       i_write_reg_E,
    input  logic             i_mem_read_M,
    input  logic [4:0]       i_write_reg_M,
    input  logic             i_branch_D,
    input  logic             i_pc_src_D,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic [1:0]       o_state,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int unsigned       DCNT_W     = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    seq_state_e        state_q;
    logic              drain_q;
    logic [DCNT_W-1:0] drain_cnt_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic load_use;
    logic br_haz;
    logic adv;
    logic stall;
    logic halt_hit;
    logic drain_done;

    hazard_detect u_hazard_detect (
        .rs_d_i        (i_instr_rs_D),
        .rt_d_i        (i_instr_rt_D),
        .mem_read_e_i  (i_mem_read_E),
        .rt_e_i        (i_instr_rt_E),
        .reg_write_e_i (i_reg_write_E),
        .write_reg_e_i (i_write_reg_E),
        .mem_read_m_i  (i_mem_read_M),
        .write_reg_m_i (i_write_reg_M),
        .branch_d_i    (i_branch_D),
        .load_use_o    (load_use),
        .br_haz_o      (br_haz)
    );

    always_comb begin
        adv        = (state_q == StRun) || (state_q == StStep);
        // While draining, ID only holds the HALT, so its hazards are irrelevant.
        stall      = (load_use || br_haz) && !drain_q;
        halt_hit   = i_halt_instr_D && !stall && !drain_q;
        drain_done = adv && ((drain_q && (drain_cnt_q == DRAIN_LAST)) ||
                             (halt_hit && (DRAIN_CYCLES == 1)));

        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        if (adv) begin
            o_ex_mem_en = 1'b1;
            o_mem_wb_en = 1'b1;
            if (drain_q) begin
                o_id_ex_flush = 1'b1;
            end else begin
                o_pc_en       = !stall && !halt_hit;
                o_if_id_en    = !stall && !halt_hit;
                o_id_ex_flush = stall || halt_hit;
                o_if_id_flush = i_pc_src_D && !stall && !halt_hit;
            end
        end

        o_state       = state_q;
        o_done        = (state_q == StDone);
        o_cycle_count = cycle_cnt_q;
        o_stall_count = stall_cnt_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            drain_q     <= 1'b0;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (adv) begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                end
                if (stall && (stall_cnt_q != '1)) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                if (halt_hit) begin
                    drain_q     <= 1'b1;
                    drain_cnt_q <= DCNT_W'(1);
                end else if (drain_q) begin
                    drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
                end
            end

            // Drain completion wins over any debug request in the same cycle.
            if (drain_done) begin
                state_q <= StDone;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (i_run) begin
                            state_q <= StRun;
                        end else if (i_step) begin
                            state_q <= StStep;
                        end
                    end
                    StRun: begin
                        if (i_halt_req) begin
                            state_q <= StIdle;
                        end
                    end
                    StStep: state_q <= StIdle;
                    StDone: state_q <= StDone;
                endcase
            end
        end
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Global run/step/halt sequencer for the 5-stage MIPS pipeline. It sits beside the forwarding logic and decides each cycle whether the pipeline advances. It owns the stall/flush hazard logic that forwarding cannot cover: load-use and branch-compare-in-ID. It drains the pipeline after a HALT instruction, and exposes cycle and stall counters to the debug unit.

## Interface
- DRAIN_CYCLES, 3: advance cycles from HALT detection in ID until DONE, detection cycle included.
- CNT_W, 32: width of the cycle and stall counters.
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_run  in  1  debug: enter continuous run (level sampled each cycle).
- i_step  in  1  debug: single-cycle advance request.
- i_halt_req  in  1  debug: pause continuous run.
- i_halt_instr_D  in  1  HALT opcode decoded in ID.
- i_instr_rs_D, i_instr_rt_D  in  5 each  source registers in ID.
- i_mem_read_E  in  1  MemRead in EX.
- i_instr_rt_E  in  5  RT in EX (load destination).
- i_reg_write_E  in  1  RegWrite in EX.
- i_write_reg_E  in  5  destination register in EX, after the RegDst mux.
- i_mem_read_M  in  1  MemRead in MEM.
- i_write_reg_M  in  5  destination register in MEM.
- i_branch_D  in  1  branch instruction in ID.
- i_pc_src_D  in  1  branch taken, resolved in ID.
- o_pc_en, o_if_id_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage register enables.
- o_if_id_flush, o_id_ex_flush  out  1 each  bubble insertion.
- o_state  out  2  IDLE=0, RUN=1, STEP=2, DONE=3.
- o_done  out  1  state==DONE.
- o_cycle_count, o_stall_count  out  CNT_W each  saturating counters.

## Operation
- adv = state∈{RUN,STEP}. All outputs derive from registered state plus current inputs; no output is registered separately.
- load_use = i_mem_read_E & rt_E≠0 & (rt_E==rs_D | rt_E==rt_D).
- br_haz = i_branch_D & [(i_reg_write_E & wr_E≠0 & wr_E∈{rs_D,rt_D}) | (i_mem_read_M & wr_M≠0 & wr_M∈{rs_D,rt_D})].
- stall = (load_use | br_haz) & ~drain.
- When adv=0: every enable is 0 and every flush is 0. The pipeline is frozen.
- When adv=1 and not draining:
  - o_ex_mem_en = o_mem_wb_en = 1.
  - o_pc_en = o_if_id_en = ~stall & ~halt_hit.
  - o_id_ex_flush = stall | halt_hit.
  - o_if_id_flush = i_pc_src_D & ~stall & ~halt_hit.
- halt_hit = i_halt_instr_D & ~stall & ~drain. Stall has priority; HALT is re-evaluated next cycle because it is still held in ID.
- halt_hit sets drain and loads drain_cnt=1.
- When adv=1 and draining: pc and IF/ID are disabled, o_id_ex_flush=1, EX/MEM and MEM/WB advance, and drain_cnt increments.
- Drain completes when an advance cycle occurs with drain_cnt==DRAIN_CYCLES-1, or with halt_hit when DRAIN_CYCLES==1. The state then goes to DONE.
- State transitions (registered):
  - IDLE: i_run→RUN, else i_step→STEP (run has priority).
  - RUN: i_halt_req→IDLE. The cycle in which i_halt_req is seen still advances.
  - STEP: →IDLE unconditionally.
  - DONE: held until reset; i_run, i_step and i_halt_req are ignored.
  - Drain completion overrides every other transition.
- Drain progresses only on advance cycles, so stepping through a drain takes DRAIN_CYCLES steps.
- o_cycle_count increments on every adv cycle. o_stall_count increments on adv & stall. Both saturate at all-ones.

## Timing
- Reset (asynchronous, immediate): state=IDLE, drain=0, drain_cnt=0, counters=0. All enables and flushes are 0 and o_done=0.
- A reset asserted mid-drain or mid-step aborts immediately. No partial advance occurs after deassert.
- Latency:
  - i_run or i_step in cycle t → first advance cycle is t+1.
  - STEP gives exactly one advance cycle.
  - i_halt_req in cycle t → last advance cycle is t, frozen from t+1.
- HALT first hit in advance cycle t, with continuous run: advance cycles t … t+DRAIN_CYCLES-1, then o_done=1 from t+DRAIN_CYCLES.
- Simultaneous events:
  - stall & i_pc_src_D: stall wins, no IF/ID flush.
  - i_halt_req during DRAIN in RUN: goes to IDLE with drain retained.
  - i_run & i_step in IDLE: RUN.

## Structure
- Shared package `pipeline_ctrl_pkg`: state encoding constants (IDLE/RUN/STEP/DONE) and the DRAIN_CYCLES default.
- One combinational sub-module, `hazard_detect`, produces load_use and br_haz from the register-compare inputs. The FSM, drain counter and statistics counters stay in pipeline_sequencer.

## Test plan
- Reset, then i_step pulsed 3 times → exactly 3 cycles with o_pc_en=1, o_cycle_count=3, o_state back to 0.
- Running; EX holds lw $5 (i_mem_read_E=1, rt_E=5); ID uses rs_D=5 → one cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; o_stall_count=1.
- Running; i_branch_D=1, rs_D=8, i_reg_write_E=1, wr_E=8 → stall, then the next cycle with i_pc_src_D=1 → o_if_id_flush=1, o_pc_en=1.
- Running; i_halt_instr_D=1 at cycle t → o_pc_en=0 from t, o_ex_mem_en=1 for t..t+2, o_done=1 and o_state=3 at t+3; a later i_run is ignored.
- HALT hit in STEP mode → DONE only after the 3rd step pulse; o_cycle_count matches the number of steps.
- i_reset asserted during drain → all outputs 0 and o_state=0 in the same cycle; counters cleared.
